// File: rtl/kuznechik_pkg.sv
// Shared types for the kuznechik arbiter slice.
//   BLK_W       : cipher block width
//   block_t     : one cipher block
//   arb_state_t : arbiter FSM states
package kuznechik_pkg;

  localparam int BLK_W = 128;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/kuznechik_rr_pick.sv
// Round-robin picker, purely combinational.
//   req   : request vector
//   ptr   : index with highest priority this round
//   found : any request set
//   idx   : first set bit at or after ptr, wrapping modulo N_REQ
module kuznechik_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    off;
  logic [IW:0]      sum;

  // Rotate so bit 0 of rot is requester ptr; a plain priority encode then
  // gives the offset from the pointer.
  assign rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = IW'(i);
  end

  assign found = |req;
  assign sum   = {1'b0, ptr} + {1'b0, off};
  assign idx   = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : sum[IW-1:0];

endmodule

// File: rtl/kuznechik_arbiter.sv
// Shares one kuznechik_cipher among N_REQ requesters, one block in flight.
//   clk, rst        : clock, synchronous active-high reset (also resets cipher)
//   req_valid_i     : per-requester block pending, held until accepted
//   req_data_i      : per-requester plaintext, slice k for requester k
//   req_accept_o    : one-cycle pulse, plaintext of requester k latched
//   rsp_valid_o     : result ready for requester k, held until acked
//   rsp_data_o      : shared ciphertext
//   rsp_ack_i       : requester k consumed its result
//   cph_*_o/_i      : handshake with the shared cipher
//   grant_o, busy_o : current owner, arbiter not idle
module kuznechik_arbiter #(
  parameter int N_REQ = 4,
  parameter int BLK_W = kuznechik_pkg::BLK_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ-1:0][BLK_W-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_accept_o,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic [BLK_W-1:0]            rsp_data_o,
  input  logic [N_REQ-1:0]            rsp_ack_i,
  output logic [BLK_W-1:0]            cph_data_o,
  output logic                        cph_request_o,
  output logic                        cph_ack_o,
  input  logic [BLK_W-1:0]            cph_data_i,
  input  logic                        cph_valid_i,
  input  logic                        cph_busy_i,
  output logic [$clog2(N_REQ)-1:0]    grant_o,
  output logic                        busy_o
);

  import kuznechik_pkg::*;

  localparam int IW = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    rr_q, grant_q;
  logic [N_REQ-1:0] accept_q, grant_oh;
  logic [BLK_W-1:0] cph_data_q, rsp_data_q;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             own_ack;

  kuznechik_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_valid_i),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign grant_oh = N_REQ'(1) << grant_q;
  // Only the owner's ack counts; other bits are don't-care.
  assign own_ack  = rsp_ack_i[grant_q];

  // State register and datapath latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      accept_q   <= '0;
      cph_data_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q  <= state_d;
      accept_q <= '0;
      // Grant and plaintext change only on leaving IDLE, so both stay
      // frozen for the whole block regardless of req_valid_i.
      if (state_q == ST_IDLE && pick_found) begin
        grant_q    <= pick_idx;
        cph_data_q <= req_data_i[pick_idx];
        accept_q   <= N_REQ'(1) << pick_idx;
      end
      if (state_q == ST_WAIT && cph_valid_i)
        rsp_data_q <= cph_data_i;
      if (state_q == ST_RESP && own_ack)
        rr_q <= (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_found)  state_d = ST_ISSUE;
      ST_ISSUE: if (!cph_busy_i) state_d = ST_WAIT;
      ST_WAIT:  if (cph_valid_i) state_d = ST_RESP;
      ST_RESP:  if (own_ack)     state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cph_request_o = 1'b0;
    cph_ack_o     = 1'b0;
    rsp_valid_o   = '0;
    unique case (state_q)
      ST_ISSUE: cph_request_o = !cph_busy_i;
      ST_RESP: begin
        rsp_valid_o = grant_oh;
        cph_ack_o   = own_ack;
      end
      default: ;
    endcase
  end

  assign req_accept_o = accept_q;
  assign rsp_data_o   = rsp_data_q;
  assign cph_data_o   = cph_data_q;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_kuznechik_arbiter.sv
module tb_kuznechik_arbiter;
  import kuznechik_pkg::*;

  typedef struct {
    int     idx;
    block_t data;
  } exp_t;

  localparam block_t P029 = 128'hc177d2d35af6d17477545bfcf97d43a4;
  localparam block_t E029 = 128'h3e882d2ca5092e8b88aba40306_82bc5b;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid, req_accept, rsp_valid, rsp_ack;
  logic [3:0][127:0] req_data;
  block_t          rsp_data, cph_data, cph_dout;
  logic            cph_request, cph_ack, cph_valid, cph_busy;
  logic [1:0]      grant;
  logic            busy;

  logic            mdl_busy, force_busy;
  int              mdl_cnt;

  int              n_chk = 0, n_err = 0;
  exp_t            sb[$];
  int              acc_cnt[4];
  int              creq_cnt = 0;
  int              acc0[4];
  int              creq0;

  always #5 clk = ~clk;

  kuznechik_arbiter #(.N_REQ(4), .BLK_W(128)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_accept_o  (req_accept),
    .rsp_valid_o   (rsp_valid),
    .rsp_data_o    (rsp_data),
    .rsp_ack_i     (rsp_ack),
    .cph_data_o    (cph_data),
    .cph_request_o (cph_request),
    .cph_ack_o     (cph_ack),
    .cph_data_i    (cph_dout),
    .cph_valid_i   (cph_valid),
    .cph_busy_i    (cph_busy),
    .grant_o       (grant),
    .busy_o        (busy)
  );

  // Behavioural cipher: busy from the cycle after request, valid 10 cycles
  // later and held until ack, result is the bitwise inverse.
  assign cph_busy = mdl_busy | force_busy;

  always @(posedge clk) begin
    if (rst) begin
      mdl_busy  <= 1'b0;
      cph_valid <= 1'b0;
      mdl_cnt   <= 0;
      cph_dout  <= '0;
    end else begin
      if (cph_request) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= 10;
        cph_dout <= cph_data ^ {128{1'b1}};
      end else if (mdl_cnt > 1) begin
        mdl_cnt <= mdl_cnt - 1;
      end else if (mdl_cnt == 1) begin
        mdl_cnt   <= 0;
        cph_valid <= 1'b1;
      end
      if (cph_ack) begin
        cph_valid <= 1'b0;
        mdl_busy  <= 1'b0;
      end
    end
  end

  // Pulse counters, sampled mid-cycle
  initial for (int k = 0; k < 4; k++) acc_cnt[k] = 0;
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (req_accept[k]) acc_cnt[k]++;
    if (cph_request) creq_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int k = 0; k < 4; k++) acc0[k] = acc_cnt[k];
    creq0 = creq_cnt;
  endtask

  task automatic wait_accept(input int k);
    int n = 0;
    while (!req_accept[k] && n < 20) begin
      tick();
      n++;
    end
    chk("accept_seen", 128'(req_accept[k]), 128'(1));
  endtask

  task automatic wait_rsp();
    int   n = 0;
    exp_t e;
    while (rsp_valid == 4'b0 && n < 60) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      chk("sb_nonempty", 128'(0), 128'(1));
    end else begin
      e = sb.pop_front();
      chk("rsp_valid", 128'(rsp_valid), 128'(1) << e.idx);
      chk("rsp_grant", 128'(grant), 128'(e.idx));
      chk("rsp_data", rsp_data, e.data);
    end
  endtask

  task automatic ack_rsp();
    rsp_ack = rsp_valid;
    #1;
    chk("cph_ack", 128'(cph_ack), 128'(1));
    tick();
    rsp_ack = 4'b0;
    chk("idle_after_ack", 128'(busy), 128'(0));
  endtask

  task automatic serve();
    wait_rsp();
    ack_rsp();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_grant"},  128'(grant), 128'(0));
    chk({tag, "_busy"},   128'(busy), 128'(0));
    chk({tag, "_accept"}, 128'(req_accept), 128'(0));
    chk({tag, "_rspv"},   128'(rsp_valid), 128'(0));
    chk({tag, "_rspd"},   rsp_data, 128'(0));
    chk({tag, "_cdata"},  cph_data, 128'(0));
    chk({tag, "_creq"},   128'(cph_request), 128'(0));
    chk({tag, "_cack"},   128'(cph_ack), 128'(0));
  endtask

  initial begin
    block_t d;
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ack = '0; force_busy = 1'b0;
    repeat (3) tick();
    chk_reset_outs("rst");
    rst = 1'b0;
    tick();

    // Single requester, known vector
    snap();
    req_data[0] = P029;
    req_valid   = 4'b0001;
    sb.push_back('{idx: 0, data: E029});
    wait_accept(0);
    req_valid = '0;
    chk("grant_single", 128'(grant), 128'(0));
    chk("cdata_single", cph_data, P029);
    tick();
    chk("accept_one_cycle", 128'(req_accept), 128'(0));
    serve();
    chk("creq_single", 128'(creq_cnt - creq0), 128'(1));
    chk("acc_single", 128'(acc_cnt[0] - acc0[0]), 128'(1));
    repeat (3) tick();
    chk("idle_hold_rspd", rsp_data, E029);
    chk("idle_hold_grant", 128'(grant), 128'(0));

    // All four held from reset: order 0,1,2,3,0
    rst = 1'b1;
    for (int k = 0; k < 4; k++) req_data[k] = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 4'b1111;
    tick(); tick();
    snap();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) sb.push_back('{idx: k % 4, data: ~req_data[k % 4]});
    for (int k = 0; k < 5; k++) serve();
    req_valid = '0;
    chk("acc_rr0", 128'(acc_cnt[0] - acc0[0]), 128'(2));
    for (int k = 1; k < 4; k++) chk("acc_rr", 128'(acc_cnt[k] - acc0[k]), 128'(1));
    chk("creq_rr", 128'(creq_cnt - creq0), 128'(5));

    // Pointer wrap: serve 2 (pointer -> 3), then 2 alone again
    for (int r = 0; r < 2; r++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      req_data[2] = d;
      req_valid   = 4'b0100;
      sb.push_back('{idx: 2, data: ~d});
      wait_accept(2);
      req_valid = '0;
      chk("wrap_grant", 128'(grant), 128'(2));
      serve();
    end

    // Cipher busy for 5 cycles while in ISSUE
    snap();
    d = {$urandom, $urandom, $urandom, $urandom};
    req_data[1] = d;
    force_busy  = 1'b1;
    req_valid   = 4'b0010;
    sb.push_back('{idx: 1, data: ~d});
    wait_accept(1);
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      chk("busy_no_req", 128'(cph_request), 128'(0));
      chk("busy_cdata", cph_data, d);
      tick();
    end
    force_busy = 1'b0;
    #1;
    chk("busy_release_req", 128'(cph_request), 128'(1));
    serve();
    chk("busy_creq_cnt", 128'(creq_cnt - creq0), 128'(1));

    // Foreign ack bits ignored; ack outside RESP ignored
    d = {$urandom, $urandom, $urandom, $urandom};
    req_data[1] = d;
    req_valid   = 4'b0010;
    sb.push_back('{idx: 1, data: ~d});
    wait_accept(1);
    req_valid = '0;
    tick();
    rsp_ack = 4'b1111;
    #1;
    chk("ack_in_wait", 128'(cph_ack), 128'(0));
    tick();
    rsp_ack = '0;
    chk("wait_still_busy", 128'(busy), 128'(1));
    wait_rsp();
    rsp_ack = 4'b0100;
    #1;
    chk("foreign_ack", 128'(cph_ack), 128'(0));
    tick();
    chk("foreign_hold_rspv", 128'(rsp_valid), 128'(4'b0010));
    chk("foreign_hold_busy", 128'(busy), 128'(1));
    ack_rsp();
    chk("acked_rspv", 128'(rsp_valid), 128'(0));

    // Reset during WAIT aborts silently; next grant from requester 0
    d = {$urandom, $urandom, $urandom, $urandom};
    req_data[2] = d;
    req_valid   = 4'b0100;
    sb.push_back('{idx: 2, data: ~d});
    wait_accept(2);
    req_valid = '0;
    repeat (4) tick();
    chk("pre_abort_busy", 128'(busy), 128'(1));
    snap();
    rst = 1'b1;
    tick();
    chk_reset_outs("abort");
    sb.delete();
    rst = 1'b0;
    req_data[0] = {$urandom, $urandom, $urandom, $urandom};
    req_data[3] = {$urandom, $urandom, $urandom, $urandom};
    req_valid   = 4'b1001;
    sb.push_back('{idx: 0, data: ~req_data[0]});
    sb.push_back('{idx: 3, data: ~req_data[3]});
    serve();
    serve();
    req_valid = '0;
    chk("abort_no_acc2", 128'(acc_cnt[2] - acc0[2]), 128'(0));
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
